// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-bank responder with independent AW/W buffers and B/R response generation.
// Optional non-secure access filtering: define AXIL_REG_SLAVE_SECURE_CHECK_EN.
module axil_reg_slave #(
  parameter int unsigned N_REGS                          = 8,
  parameter int unsigned DATA_WIDTH                      = 32,
  parameter int unsigned ADDR_WIDTH                      = 32,
  parameter logic [N_REGS*DATA_WIDTH-1:0] RESET_VAL_FLAT = '0,
  parameter logic [N_REGS-1:0] SECURE_REGS               = '0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic [2:0]                   awprot_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic [2:0]                   arprot_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [N_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [N_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                  live_q;
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [N_REGS-1:0]     pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [N_REGS];
  logic [DATA_WIDTH-1:0] regs_d [N_REGS];

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] aw_idx_in, ar_idx;
  logic             aw_ok, ar_ok;
  logic             unused_inputs;

  assign aw_idx_in = awaddr_i[ADDR_LSB +: IDX_W];
  assign ar_idx    = araddr_i[ADDR_LSB +: IDX_W];

  // Ready outputs stay low until the first clock edge after reset release.
  assign awready_o = live_q && !aw_full_q;
  assign wready_o  = live_q && !w_full_q;
  assign arready_o = live_q && (!rvalid_q || rready_i);

  assign aw_hs  = awvalid_i && awready_o;
  assign w_hs   = wvalid_i && wready_o;
  assign ar_hs  = arvalid_i && arready_o;
  assign commit = aw_full_q && w_full_q && (!bvalid_q || bready_i);

`ifdef AXIL_REG_SLAVE_SECURE_CHECK_EN
  logic aw_ns_q, aw_ns_d;

  assign aw_ok = (32'(aw_idx_q) < N_REGS) && !(aw_ns_q && SECURE_REGS[aw_idx_q]);
  assign ar_ok = (32'(ar_idx) < N_REGS) && !(arprot_i[1] && SECURE_REGS[ar_idx]);
  assign aw_ns_d = aw_hs ? awprot_i[1] : aw_ns_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) aw_ns_q <= 1'b0;
    else          aw_ns_q <= aw_ns_d;
  end

  assign unused_inputs = ^{awaddr_i, araddr_i, awprot_i[2], awprot_i[0], arprot_i[2], arprot_i[0]};
`else
  assign aw_ok = 32'(aw_idx_q) < N_REGS;
  assign ar_ok = 32'(ar_idx) < N_REGS;
  assign unused_inputs = ^{awaddr_i, araddr_i, awprot_i, arprot_i};
`endif

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    bvalid_d  = bvalid_q && !bready_i;
    rvalid_d  = rvalid_q && !rready_i;

    // Handshakes only happen into empty buffers and commit only drains full ones, so order is free.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
      if (aw_ok) begin
        pulse_d[aw_idx_q] = 1'b1;
        for (int unsigned k = 0; k < STRB_W; k++) begin
          if (wstrb_q[k]) regs_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
        end
      end
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aw_idx_in;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end

    // Reads sample regs_q, so a read colliding with a commit sees the old value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? regs_q[ar_idx] : '0;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= RESET_VAL_FLAT[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      live_q    <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign rresp_o    = rresp_q;
  assign wr_pulse_o = pulse_q;

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
    assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: a queue-based transaction model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_axil_reg_slave;

  localparam int unsigned NR = 6;
  localparam logic [NR*32-1:0] RV = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                                     32'h2222_0002, 32'h1111_0001, 32'hC0DE_0000};
  localparam logic [NR-1:0] SEC = 6'h01;
`ifdef AXIL_REG_SLAVE_SECURE_CHECK_EN
  localparam bit SECURE_EN = 1'b1;
`else
  localparam bit SECURE_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready_o;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready_o;
  logic [1:0]    bresp_o;
  logic          bvalid_o;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready_o;
  logic [31:0]   rdata_o;
  logic [1:0]    rresp_o;
  logic          rvalid_o;
  logic          rready = 1'b0;
  logic [NR*32-1:0] reg_o;
  logic [NR-1:0] wr_pulse_o;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_reg_slave #(
    .N_REGS(NR), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .RESET_VAL_FLAT(RV), .SECURE_REGS(SEC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready_o),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_regs [NR];
  logic [34:0] aw_q [$];   // {prot, addr}
  logic [35:0] w_q  [$];   // {strb, data}
  bit          m_live, m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [NR-1:0] m_pulse;

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % 8;
  endfunction

  function automatic bit m_ok(input logic [31:0] a, input logic [2:0] p);
    int unsigned i = m_idx(a);
    bit ok = (i < NR);
    if (SECURE_EN && ok && p[1] && SEC[i]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [NR*32-1:0] m_flat();
    logic [NR*32-1:0] f = '0;
    for (int i = 0; i < NR; i++) f = f | ({{(NR-1)*32{1'b0}}, m_regs[i]} << (32 * i));
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 32'((RV >> (32 * i)) & {{(NR-1)*32{1'b0}}, 32'hFFFF_FFFF});
    aw_q.delete(); w_q.delete();
    m_live = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0; m_pulse = '0;
  endtask

  task automatic model_step();
    bit aw_hs, w_hs, ar_hs, cm;
    logic [34:0] a;
    logic [35:0] w;
    logic [31:0] mask;
    aw_hs = awvalid && m_live && aw_q.size() == 0;
    w_hs  = wvalid && m_live && w_q.size() == 0;
    ar_hs = arvalid && m_live && (!m_rvalid || rready);
    cm    = aw_q.size() != 0 && w_q.size() != 0 && (!m_bvalid || bready);
    if (ar_hs) begin
      m_rvalid = 1;
      m_rdata  = m_ok(araddr, arprot) ? m_regs[m_idx(araddr)] : 32'h0;
      m_rresp  = m_ok(araddr, arprot) ? 2'b00 : 2'b10;
    end else if (rready) m_rvalid = 0;
    m_pulse = '0;
    if (cm) begin
      a = aw_q.pop_front();
      w = w_q.pop_front();
      m_bvalid = 1;
      if (m_ok(a[31:0], a[34:32])) begin
        mask = {{8{w[35]}}, {8{w[34]}}, {8{w[33]}}, {8{w[32]}}};
        m_regs[m_idx(a[31:0])] = (m_regs[m_idx(a[31:0])] & ~mask) | (w[31:0] & mask);
        m_pulse[m_idx(a[31:0])] = 1'b1;
        m_bresp = 2'b00;
      end else m_bresp = 2'b10;
    end else if (bready) m_bvalid = 0;
    if (aw_hs) aw_q.push_back({awprot, awaddr});
    if (w_hs)  w_q.push_back({wstrb, wdata});
    m_live = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge aclk);
      chk("awready", awready_o, m_live && aw_q.size() == 0);
      chk("wready", wready_o, m_live && w_q.size() == 0);
      chk("arready", arready_o, m_live && (!m_rvalid || rready));
      chk("bvalid", bvalid_o, m_bvalid);
      if (m_bvalid) chk("bresp", bresp_o, m_bresp);
      chk("rvalid", rvalid_o, m_rvalid);
      if (m_rvalid) begin
        chk("rdata", rdata_o, m_rdata);
        chk("rresp", rresp_o, m_rresp);
      end
      chk("reg_o", reg_o, m_flat());
      chk("wr_pulse", wr_pulse_o, m_pulse);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge aclk);
    #1;
  endtask

  // Returns in the cycle where the response and register update are visible.
  task automatic write_c2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    cyc();
    awvalid = 0; wvalid = 0;
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_awready", awready_o, 0);
    chk("rst_arready", arready_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_reg_o", reg_o, RV);
    aresetn = 1;
    cyc();
    chk("live_awready", awready_o, 1);
    chk("live_arready", arready_o, 1);

    // back-to-back reads of every register
    rready = 1;
    for (int i = 0; i < NR; i++) begin
      arvalid = 1; araddr = 32'(i * 4);
      cyc();
      if (i == 0) chk("rd0_data", rdata_o, 32'hC0DE_0000);
      if (i == 4) chk("rd4_data", rdata_o, 32'h4444_0004);
    end
    arvalid = 0;
    cyc();

    // AW and W together, bready high
    bready = 1;
    write_c2(32'h04, 32'hDEAD_BEEF, 4'hF);
    chk("w1_bvalid", bvalid_o, 1);
    chk("w1_bresp", bresp_o, 2'b00);
    chk("w1_reg1", reg_o[63:32], 32'hDEAD_BEEF);
    chk("w1_pulse", wr_pulse_o, 6'h02);
    cyc();
    chk("w1_pulse_end", wr_pulse_o, 6'h00);
    cyc();

    // W three cycles ahead of AW
    write_c2(32'h08, 32'h1122_3344, 4'hF);
    cyc();
    wvalid = 1; wdata = 32'h0000_00AA; wstrb = 4'h1;
    cyc();
    wvalid = 0;
    chk("wfirst_wready", wready_o, 0);
    chk("wfirst_awready", awready_o, 1);
    cyc(); cyc();
    awvalid = 1; awaddr = 32'h08;
    cyc();
    awvalid = 0;
    chk("wfirst_awready_full", awready_o, 0);
    cyc();
    chk("wfirst_bresp", bresp_o, 2'b00);
    chk("wfirst_reg2", reg_o[95:64], 32'h1122_33AA);
    cyc();

    // out-of-range write and read, aliasing through ignored address bits, zero strobe
    write_c2(32'h18, 32'hFFFF_FFFF, 4'hF);
    chk("oor_bresp", bresp_o, 2'b10);
    chk("oor_pulse", wr_pulse_o, 6'h00);
    cyc();
    arvalid = 1; araddr = 32'h18;
    cyc();
    arvalid = 0;
    chk("oor_rresp", rresp_o, 2'b10);
    chk("oor_rdata", rdata_o, 32'h0);
    write_c2(32'hFFFF_FF2C, 32'hA5A5_5A5A, 4'b0101);
    chk("alias_reg3", reg_o[127:96], 32'h33A5_005A);
    chk("alias_pulse", wr_pulse_o, 6'h08);
    cyc();
    write_c2(32'h0F, 32'h0, 4'b0000);
    chk("strb0_bresp", bresp_o, 2'b00);
    chk("strb0_pulse", wr_pulse_o, 6'h08);
    chk("strb0_reg3", reg_o[127:96], 32'h33A5_005A);
    cyc();

    // B backpressure with a second write waiting
    bready = 0;
    write_c2(32'h10, 32'h4040_4040, 4'hF);
    awvalid = 1; awaddr = 32'h18; wvalid = 1; wdata = 32'h5050_5050; wstrb = 4'hF;
    cyc();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", bvalid_o, 1);
      chk("bp_bresp", bresp_o, 2'b00);
      chk("bp_awready", awready_o, 0);
      chk("bp_wready", wready_o, 0);
      cyc();
    end
    bready = 1;
    cyc();
    chk("bp_second_bvalid", bvalid_o, 1);
    chk("bp_second_bresp", bresp_o, 2'b10);
    cyc();
    chk("bp_drained", bvalid_o, 0);

    // R backpressure
    rready = 0;
    arvalid = 1; araddr = 32'h10;
    cyc();
    arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rbp_rdata", rdata_o, 32'h4040_4040);
      chk("rbp_arready", arready_o, 0);
      cyc();
    end
    rready = 1;
    cyc();
    chk("rbp_drained", rvalid_o, 0);

    // read and commit to the same register on the same edge
    awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    cyc();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h04;
    cyc();
    arvalid = 0;
    chk("rw_old_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rw_new_reg1", reg_o[63:32], 32'h0BAD_F00D);
    cyc();

    // reset with only AW buffered
    awvalid = 1; awaddr = 32'h04;
    cyc();
    awvalid = 0;
    #2 aresetn = 0;
    #1;
    chk("mid_rst_bvalid", bvalid_o, 0);
    chk("mid_rst_reg_o", reg_o, RV);
    cyc();
    aresetn = 1;
    cyc();
    wvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    cyc();
    wvalid = 0;
    cyc(); cyc();
    chk("mid_rst_no_commit", bvalid_o, 0);
    chk("mid_rst_regs", reg_o, RV);
    awvalid = 1; awaddr = 32'h00;
    cyc();
    awvalid = 0;
    cyc();
    chk("post_rst_reg0", reg_o[31:0], 32'hFFFF_FFFF);
    cyc();

`ifdef AXIL_REG_SLAVE_SECURE_CHECK_EN
    awprot = 3'b010;
    write_c2(32'h00, 32'h1234_5678, 4'hF);
    chk("sec_ns_bresp", bresp_o, 2'b10);
    chk("sec_ns_reg0", reg_o[31:0], 32'hFFFF_FFFF);
    chk("sec_ns_pulse", wr_pulse_o, 6'h00);
    cyc();
    awprot = 3'b000;
    write_c2(32'h00, 32'h1234_5678, 4'hF);
    chk("sec_s_bresp", bresp_o, 2'b00);
    chk("sec_s_reg0", reg_o[31:0], 32'h1234_5678);
    cyc();
    arprot = 3'b010; arvalid = 1; araddr = 32'h00;
    cyc();
    arvalid = 0; arprot = 3'b000;
    chk("sec_ns_rresp", rresp_o, 2'b10);
    chk("sec_ns_rdata", rdata_o, 32'h0);
    cyc();
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder terminating one slave port of the bus matrix.
- Holds a bank of N_REGS software-visible registers with byte-strobe writes.
- Implements the AW/W/B and AR/R channels independently, with single-entry AW and W holding buffers.
- Generates OKAY/SLVERR responses.
- Exports register contents and per-register write pulses to the surrounding IP.

Parameters:
- N_REGS, 8, number of DATA_WIDTH registers; 1..256.
- DATA_WIDTH, 32, data bus width; 32 or 64.
- ADDR_WIDTH, 32, address width.
- RESET_VAL_FLAT, '0, N_REGS*DATA_WIDTH reset values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- SECURE_REGS, '0, N_REGS-bit mask; bit i=1 marks register i secure-only (used only with the optional feature).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awaddr_i  in  ADDR_WIDTH  write address
- awprot_i  in  3  write protection
- awvalid_i  in  1
- awready_o  out  1
- wdata_i  in  DATA_WIDTH
- wstrb_i  in  DATA_WIDTH/8
- wvalid_i  in  1
- wready_o  out  1
- bresp_o  out  2
- bvalid_o  out  1
- bready_i  in  1
- araddr_i  in  ADDR_WIDTH
- arprot_i  in  3
- arvalid_i  in  1
- arready_o  out  1
- rdata_o  out  DATA_WIDTH
- rresp_o  out  2
- rvalid_o  out  1
- rready_i  in  1
- reg_o  out  N_REGS*DATA_WIDTH  current register contents
- wr_pulse_o  out  N_REGS  one-cycle pulse on committed write to register i

Behaviour:
- Reset (aresetn low, asynchronous) drives the following values, and any in-flight transaction is discarded without a response:
  - all outputs 0, except awready_o=wready_o=arready_o=1 one cycle after deassert;
  - registers = RESET_VAL_FLAT;
  - AW/W buffers empty.
- Address decode:
  - index = addr[ADDR_LSB +: IDX_W], where ADDR_LSB = log2(DATA_WIDTH/8) and IDX_W = max(1, clog2(N_REGS));
  - upper address bits are ignored (the matrix already decoded the region);
  - low ADDR_LSB bits are ignored;
  - index >= N_REGS is out of range.
- AW buffer:
  - awready_o = !aw_full;
  - on awvalid_i && awready_o, capture awaddr/awprot and set aw_full.
- W buffer:
  - wready_o = !w_full;
  - on wvalid_i && wready_o, capture wdata/wstrb and set w_full.
- AW and W may arrive in either order or in the same cycle; neither waits for the other.
- Commit condition: aw_full && w_full && (!bvalid_o || bready_i). At that edge:
  - if in range: each byte k with wstrb[k]=1 is written; other bytes are unchanged; wr_pulse_o[index]=1 for one cycle; bresp_o=OKAY(00);
  - if out of range: no register changes, no pulse, bresp_o=SLVERR(10);
  - bvalid_o set, both buffers cleared.
- Write latency: AW+W handshake in cycle 0 -> commit edge at end of cycle 1 -> bvalid_o, reg_o update and wr_pulse_o visible in cycle 2.
- B channel:
  - bvalid_o holds with stable bresp_o until bready_i;
  - a new response may replace it in the same cycle bready_i is sampled high (back-to-back).
- Read path:
  - arready_o = !rvalid_o || rready_i;
  - on AR handshake, next cycle rvalid_o=1, rdata_o = register[index], rresp_o=OKAY;
  - out of range gives rdata_o=0, rresp_o=SLVERR;
  - rdata_o/rresp_o stay stable while rvalid_o && !rready_i.
  - Read latency is 1 cycle; full throughput of one read per cycle when rready_i is held high.
- Read/write same register at the same edge: the read returns the pre-commit value.
- wstrb_i=0 with an in-range address: OKAY response, no data change, wr_pulse_o still asserted.
- awprot/arprot are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: AXIL_REG_SLAVE_SECURE_CHECK_EN.
- Defined: an access with prot[1]=1 (non-secure) to a register whose SECURE_REGS bit is 1 is treated as out of range:
  - writes return SLVERR, make no change and produce no pulse;
  - reads return SLVERR with rdata_o=0.
- Undefined: prot is ignored, SECURE_REGS is unused, and no extra logic is generated.

Test Plan:
- Reset then read reg 0..N_REGS-1 -> rdata equals RESET_VAL_FLAT slices, rresp=00, rvalid 1 cycle after AR handshake.
- AW 0x04 and W 0xDEADBEEF/strb 0xF in the same cycle, bready=1 -> bvalid in cycle 2 with bresp=00, reg_o[1]=0xDEADBEEF, wr_pulse_o=0x02 for exactly 1 cycle.
- W (0x000000AA, strb 0x1) sent 3 cycles before AW 0x08, reg 2 preloaded 0x11223344 -> wready low after W accepted, awready low after AW accepted, reg2=0x112233AA, OKAY.
- Write to address N_REGS*4, then read it -> bresp=10, no reg_o change, no pulse; rresp=10, rdata=0.
- bready held 0 for 5 cycles with a second AW+W pending -> bvalid/bresp stable, awready=wready=0, second commit occurs in the same cycle bready rises; rready low for 4 cycles -> rdata stable, arready=0.
- With AXIL_REG_SLAVE_SECURE_CHECK_EN and SECURE_REGS=0x01: write reg0 with awprot=3'b010 -> SLVERR, unchanged; same write with awprot=3'b000 -> OKAY, updated. Assert aresetn mid-write (AW buffered only) -> bvalid stays 0, buffers empty, registers back to reset values.
